// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Fixed 34-cycle latency: 32 radix-2 steps, one sign/special-case fix cycle, one done cycle.
module ex_muldiv #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   ma_q, ma_d, mb_q, mb_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic              sa_q, sa_d, sb_q, sb_d, bzero_q, bzero_d;

    logic              accept, launch, is_div, sgn_a, sgn_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   rem_sh, diff;
    logic              nonneg;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, fix_res;

    assign accept = (state_q == StIdle) || (state_q == StDone);
    assign launch = start_i & ~flush_i & accept;
    assign is_div = op_q[2];

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (op_i)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            3'd2:    sgn_a = 1'b1;
            default: ;
        endcase
    end

    // Multiply: multiplier sits in acc low half and is consumed LSB first.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, ma_q} : '0);

    // Divide: dividend shifts out of acc low half, quotient bits shift in behind it.
    assign rem_sh = {rem_q, acc_q[XLEN-1]};
    assign diff   = rem_sh - {2'b00, mb_q};
    assign nonneg = ~diff[XLEN+1];

    assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo  = bzero_q ? '1 : ((sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    assign rmd  = sa_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        if (is_div) begin
            fix_res = op_q[1] ? rmd : quo;
        end else begin
            fix_res = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bzero_d  = bzero_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (launch) begin
                    state_d = StCalc;
                    cnt_d   = '0;
                    op_d    = op_i;
                    sa_d    = sgn_a & a_i[XLEN-1];
                    sb_d    = sgn_b & b_i[XLEN-1];
                    ma_d    = (sgn_a & a_i[XLEN-1]) ? -a_i : a_i;
                    mb_d    = (sgn_b & b_i[XLEN-1]) ? -b_i : b_i;
                    bzero_d = (b_i == '0);
                    rem_d   = '0;
                    acc_d   = op_i[2] ? {{XLEN{1'b0}}, (sgn_a & a_i[XLEN-1]) ? -a_i : a_i}
                                      : {{XLEN{1'b0}}, (sgn_b & b_i[XLEN-1]) ? -b_i : b_i};
                end
            end
            StCalc: begin
                if (is_div) begin
                    rem_d = nonneg ? diff[XLEN:0] : rem_sh[XLEN:0];
                    acc_d = {{XLEN{1'b0}}, acc_q[XLEN-2:0], nonneg};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = fix_res;
                state_d  = StDone;
            end
            default: state_d = StIdle;
        endcase

        if (flush_i) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bzero_q  <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bzero_q  <= bzero_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == StCalc) || (state_q == StFix);
    assign stall_o  = busy_o | launch;
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed and randomised checks of ex_muldiv with a result scoreboard.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] a_i = 32'd0;
    logic [31:0] b_i = 32'd0;
    logic        busy_o, stall_o, done_o;
    logic [31:0] result_o;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];

    ex_muldiv #(
        .XLEN  (32),
        .CNT_W (5)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic               ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        sp  = 64'sd0;
        up  = 64'd0;
        case (op)
            3'd0: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp[31:0];
            end
            3'd1: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp[63:32];
            end
            3'd2: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
                return sp[63:32];
            end
            3'd3: begin
                up = {32'd0, a} * {32'd0, b};
                return up[63:32];
            end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 :
                         32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Call at a negedge; returns at the negedge of cycle 1 of the operation.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit push);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        start_i = 1'b0;
        a_i     = $urandom;
        b_i     = $urandom;
        op_i    = 3'($urandom_range(0, 7));
    endtask

    // Waits for done, checking latency, stall and result; optionally pokes start while busy.
    task automatic wait_done(input string tag, input int poke);
        int          lat = 1;
        bit          stall_ok = 1'b1;
        logic [31:0] exp;
        while (done_o !== 1'b1 && lat < 100) begin
            if (stall_o !== 1'b1) stall_ok = 1'b0;
            if (lat == poke) begin
                start_i = 1'b1;
                op_i    = 3'd4;
                a_i     = 32'h0000_1234;
                b_i     = 32'd7;
            end
            @(negedge clk);
            start_i = 1'b0;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd34);
        check({tag, " stall busy"}, {63'd0, stall_ok}, 64'd1);
        check({tag, " stall done"}, {63'd0, stall_o}, 64'd0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, " result"}, {32'd0, result_o}, {32'd0, exp});
    endtask

    task automatic directed(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input string tag);
        launch(op, a, b, exp, 1'b1);
        wait_done(tag, 0);
        @(negedge clk);
    endtask

    task automatic no_done(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            if (done_o !== 1'b0) seen++;
            @(negedge clk);
        end
        check({tag, " no done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        #12;
        check("rst busy", {63'd0, busy_o}, 64'd0);
        check("rst done", {63'd0, done_o}, 64'd0);
        check("rst stall", {63'd0, stall_o}, 64'd0);
        check("rst result", {32'd0, result_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        directed(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        directed(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
        directed(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        directed(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu");
        directed(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div");
        directed(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem");
        directed(3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, "divu");
        directed(3'd7, 32'hFFFF_FFF9, 32'd2,         32'd1,         "remu");
        directed(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, "div0");
        directed(3'd7, 32'd5,         32'd0,         32'd5,         "remu0");
        directed(3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, "rem0");
        directed(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div ovf");
        directed(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem ovf");

        // Back-to-back: second start issued in the first op's done cycle.
        launch(3'd0, 32'd3, 32'd5, 32'd15, 1'b1);
        wait_done("b2b first", 0);
        op_i    = 3'd5;
        a_i     = 32'd100;
        b_i     = 32'd7;
        start_i = 1'b1;
        #1;
        check("b2b stall on start", {63'd0, stall_o}, 64'd1);
        exp_q.push_back(32'd14);
        @(negedge clk);
        start_i = 1'b0;
        wait_done("b2b second", 0);
        @(negedge clk);

        // Start while busy is ignored.
        launch(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        wait_done("poke", 5);
        @(negedge clk);
        no_done("poke", 40);

        // Flush in cycle 10.
        launch(3'd0, 32'd9, 32'd9, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush busy", {63'd0, busy_o}, 64'd0);
        check("flush stall", {63'd0, stall_o}, 64'd0);
        check("flush result", {32'd0, result_o}, {32'd0, 32'hFFFF_FFFE});
        no_done("flush", 40);
        check("flush result held", {32'd0, result_o}, {32'd0, 32'hFFFF_FFFE});
        directed(3'd7, 32'd100, 32'd7, 32'd2, "after flush");

        // Flush and start together: nothing launches.
        op_i    = 3'd0;
        a_i     = 32'd4;
        b_i     = 32'd4;
        start_i = 1'b1;
        flush_i = 1'b1;
        #1;
        check("start+flush stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        flush_i = 1'b0;
        check("start+flush busy", {63'd0, busy_o}, 64'd0);
        no_done("start+flush", 40);

        for (int i = 0; i < 16; i++) begin
            rop = 3'(i % 8);
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            directed(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d op%0d", i, rop));
        end

        // Reset asserted in cycle 20 of an operation.
        launch(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst busy", {63'd0, busy_o}, 64'd0);
        check("midrst done", {63'd0, done_o}, 64'd0);
        check("midrst stall", {63'd0, stall_o}, 64'd0);
        check("midrst result", {32'd0, result_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_done("midrst", 40);
        check("midrst result held", {32'd0, result_o}, 64'd0);
        check("scoreboard empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage. It consumes operands and op-code delivered by the ID/EX pipeline register.
- Produces a 32-bit result with a fixed latency of 34 cycles.
- Asserts stall_o, which hazard control uses to freeze IF/ID and hold the instruction while the operation runs.
- flush_i (branch redirect) kills an in-flight operation.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start_i  in  1  one-cycle pulse: launch an op using op_i/a_i/b_i
flush_i  in  1  abort any operation in flight
op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a_i  in  XLEN  rs1 operand (Anum from ID/EX)
b_i  in  XLEN  rs2 operand (Bnum from ID/EX)
busy_o  out  1  operation in CALC or FIX
stall_o  out  1  combinational: busy_o OR (start_i AND state accepts start)
done_o  out  1  one-cycle pulse, result_o valid
result_o  out  XLEN  registered result, held until the next done

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all internal registers=0, busy_o=0, done_o=0, result_o=0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on start_i & ~flush_i. At that edge:
  - latch op_i;
  - latch |a_i| and |b_i| (magnitude only for signed interpretations);
  - latch sign flags: MULH/DIV/REM use both signs; MULHSU uses a sign only; unsigned ops use neither;
  - counter=0.
- CALC: one radix-2 step per cycle, 32 cycles (counter 0..31).
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit quotient and 33-bit partial remainder.
  - At counter==31 -> FIX.
- FIX, one cycle, sign/special correction, registered into result_o:
  - MUL: low 32 bits of the signed-corrected product.
  - MULH/MULHSU/MULHU: high 32 bits; product negated (64-bit two's complement) when sign flags differ.
  - DIV/DIVU: quotient negated when sa^sb (signed only).
  - REM/REMU: remainder negated when sa (signed only).
  - b==0: quotient = 0xFFFFFFFF, remainder = original a. Applies to signed and unsigned.
  - DIV overflow (a=0x80000000, b=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - FIX -> DONE.
- DONE: done_o=1 for exactly this cycle; result_o valid.
  - start_i here behaves as in IDLE (back-to-back ops); otherwise -> IDLE.
- Latency: start sampled at edge E0; done_o high during the cycle after edge E0+33, i.e. 34 cycles after start. Latency is identical for every op, including divide-by-zero and overflow.
- start_i while in CALC/FIX: ignored; operands not re-latched.
- Inputs a_i/b_i/op_i are don't-care after the start edge.
- flush_i:
  - In any state: next state IDLE, done_o not asserted, result_o unchanged.
  - Flush with start_i in the same cycle: flush wins, nothing launched.
- stall_o = (state==CALC) | (state==FIX) | (start_i & ~flush_i & (state==IDLE | state==DONE)).
  - Deasserts in the DONE cycle so the pipeline advances with result_o.
- Reset asserted mid-operation: immediate return to reset values; no done pulse after release.
- All arithmetic is modulo 2^32 (result) or 2^64 (product); no exceptions are raised.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> result_o=0xFFFFFFEB. done_o high exactly 34 cycles after start; stall_o high for the 33 cycles in between.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with 34-cycle latency.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Flush and restart:
  - Start MUL, assert flush_i in cycle 10 -> busy_o=0 and stall_o=0 next cycle, no done_o, result_o unchanged.
  - New start then completes normally.
- Back-to-back and reset:
  - start_i in the DONE cycle -> second op done 34 cycles later.
  - start_i while busy -> ignored.
  - rst_n low in cycle 20 -> all outputs 0 immediately, no done_o after release.
